lab5_ifetch: RTL
================

# lab5_ifetch

Instruction-fetch stage for the lab5 16-bit processor, directly upstream of the 128×16 instruction RAM. It owns the program counter and drives the IRAM byte address. It captures the combinationally read instruction word into an IF/ID pipeline register for decode. It also handles stalls, taken-branch redirects and HALT detection.

## Interface
- `RESET_PC`, default 8'h00: byte address loaded into the PC on reset.
- `HALT_WORD`, default 16'h0001: encoding that stops fetch.
- `NOP_WORD`, default 16'h0000: bubble encoding.

Ports:
- `CLK` in 1: single clock; all state changes on its rising edge.
- `RESET` in 1: synchronous, active-high.
- `STALL` in 1: decode hazard; hold the PC and the IF/ID register.
- `BR_TAKEN` in 1: redirect request from execute.
- `BR_TARGET` in 8: byte address of the redirect.
- `IRAM_ADDR` out 8: to IRAM `ADDR`; equals the PC register, with no logic after the flop.
- `IRAM_Q` in 16: IRAM read data; combinational from `IRAM_ADDR` in the same cycle.
- `IF_INSTR` out 16: registered instruction to decode.
- `IF_PCP2` out 8: registered PC+2 of `IF_INSTR`, used for branch offsets.
- `IF_VALID` out 1: `IF_INSTR` is a real fetched instruction, not a bubble.
- `HALTED` out 1: fetch is in the HALT state.

## Operation
- States:
  - RUN: fetching.
  - HALT: PC frozen.
- PC arithmetic:
  - 8-bit PC, always even.
  - Next sequential PC is PC+2 modulo 256, so 8'hFE wraps to 8'h00.
  - `BR_TARGET[0]` is dropped when it is loaded.
- Per-edge priority: RESET, then BR_TAKEN, then STALL, then normal.
- **RESET:**
  - PC=`RESET_PC`, state=RUN.
  - `IF_INSTR`=`NOP_WORD`, `IF_PCP2`=0, `IF_VALID`=0, `HALTED`=0.
  - These are the reset values of every output.
- **BR_TAKEN (any state):**
  - PC={`BR_TARGET[7:1]`,0}, state=RUN.
  - IF/ID is loaded with a bubble (`NOP_WORD`, valid 0, `IF_PCP2` 0).
  - The word currently at `IRAM_Q` is squashed.
  - Branch overrides a simultaneous STALL.
  - A branch arriving in HALT means the HALT was on a wrong path, so fetch resumes.
- **STALL (no branch):** PC, IF/ID and state all hold.
- **Normal, RUN, `IRAM_Q` ≠ `HALT_WORD`:**
  - IF/ID ← {`IRAM_Q`, PC+2, valid 1}.
  - PC ← PC+2.
- **Normal, RUN, `IRAM_Q` = `HALT_WORD`:**
  - IF/ID ← {`HALT_WORD`, PC+2, valid 1}, so HALT is passed to decode exactly once.
  - PC holds at the HALT address; state ← HALT.
- **Normal, HALT:**
  - IF/ID ← bubble; PC holds.
  - Exit only by RESET or BR_TAKEN.
- `HALTED` = (state == HALT), registered.
- Reset during any operation, including mid-stall or in HALT, restores all reset values on that edge.

## Timing
- `IRAM_ADDR` changes only on the clock edge, one flop from PC.
- `IRAM_Q` is sampled on the same edge the PC advances.
- Fetch latency: PC to valid `IF_INSTR` is 1 cycle.
- Throughput: 1 instruction per cycle when not stalled.
- Taken branch:
  - The edge with `BR_TAKEN`=1 puts the target on `IRAM_ADDR` and one bubble in IF/ID.
  - The next edge delivers the target instruction.
- HALT: `HALTED` rises on the same edge that presents `HALT_WORD` on `IF_INSTR`.
- First fetch after reset:
  - The IRAM loads its contents during the reset cycle.
  - The first edge with `RESET`=0 latches mem[`RESET_PC`/2].

## Structure
- Shared package `lab5_pkg`:
  - `PC_W`=8 and `INSTR_W`=16.
  - `NOP_WORD` and `HALT_WORD` constants.
  - The fetch state enum {RUN, HALT}.
  - Decode and the IRAM reuse the same constants.
- One natural sub-module: `lab5_if_id_reg`, the IF/ID pipeline register with hold (stall) and flush (bubble) controls. Decode-stage registers reuse it.
- PC register, next-PC mux and state machine stay in `lab5_ifetch`.

## Test plan
- **Reset and sequential fetch:** assert RESET 1 cycle, then run with IRAM words 16'hF001, 16'h517F.
  - `IRAM_ADDR` 00, 02, 04.
  - `IF_INSTR` F001 with `IF_PCP2` 02, then 517F with `IF_PCP2` 04.
  - `IF_VALID` goes 0 then 1.
- **Stall:** STALL=1 for 3 cycles at PC 8'h06.
  - `IRAM_ADDR` stays 06; `IF_INSTR`/`IF_PCP2`/`IF_VALID` unchanged.
  - Fetch resumes at 06 afterwards.
- **Branch with simultaneous stall:** BR_TAKEN=1, BR_TARGET=8'h4B, STALL=1.
  - Next cycle: `IRAM_ADDR`=4A, `IF_VALID`=0, `IF_INSTR`=0000.
  - Following edge: mem[37] appears with `IF_PCP2`=4C.
- **HALT:** mem[14]=16'h0001 reached.
  - `IF_INSTR`=0001 for exactly one cycle; `HALTED`=1; `IRAM_ADDR` stuck at 1C.
  - `IF_VALID`=0 for 10 further cycles.
  - Then BR_TAKEN to 8'h1E: `HALTED`=0, fetch resumes at 1E.
- **Wrap-around:** branch to 8'hFE.
  - Fetch at FE gives `IF_PCP2`=00.
  - Next `IRAM_ADDR`=00.
- **Reset mid-operation:** RESET asserted while in HALT and again while STALL=1.
  - All outputs return to reset values on that edge.
  - The fetch of `RESET_PC` follows.

Source files
------------

// File: rtl/lab5_pkg.sv
// lab5 shared definitions: datapath widths, special encodings
// and the fetch state type used by ifetch, decode and IRAM.
package lab5_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD  = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0001;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/lab5_if_id_reg.sv
// Pipeline register {instr, pc+2, valid} with hold and flush.
// Flush beats hold so a redirect can kill a stalled slot.
module lab5_if_id_reg
  import lab5_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE = lab5_pkg::NOP_WORD
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_hold,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pcp2,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pcp2,
  output logic               o_valid
);
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pcp2;
  logic               r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_instr <= BUBBLE;
      r_pcp2  <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_pcp2  <= i_pcp2;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pcp2  = r_pcp2;
  assign o_valid = r_valid;
endmodule

// File: rtl/lab5_ifetch.sv
// lab5 fetch stage: PC, next-PC mux, RUN/HALT machine, IF/ID.
// IRAM is read combinationally from the PC flop each cycle.
module lab5_ifetch
  import lab5_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_WORD = lab5_pkg::HALT_WORD,
  parameter logic [INSTR_W-1:0] NOP_WORD  = lab5_pkg::NOP_WORD
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL,
  input  logic               BR_TAKEN,
  input  logic [PC_W-1:0]    BR_TARGET,
  output logic [PC_W-1:0]    IRAM_ADDR,
  input  logic [INSTR_W-1:0] IRAM_Q,
  output logic [INSTR_W-1:0] IF_INSTR,
  output logic [PC_W-1:0]    IF_PCP2,
  output logic               IF_VALID,
  output logic               HALTED
);
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pcp2;
  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic            w_hold;
  logic            w_flush;
  logic            w_is_halt;

  assign w_pcp2    = r_pc + PC_W'(2);
  assign w_is_halt = (IRAM_Q == HALT_WORD);

  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_hold      = 1'b0;
    w_flush     = 1'b0;
    priority case (1'b1)
      BR_TAKEN: begin
        w_pc_nxt    = {BR_TARGET[PC_W-1:1], 1'b0};
        w_state_nxt = RUN;
        w_flush     = 1'b1;
      end
      STALL: w_hold = 1'b1;
      (r_state == HALT): w_flush = 1'b1;
      // HALT word goes to decode once; PC parks on it
      w_is_halt: w_state_nxt = HALT;
      default: w_pc_nxt = w_pcp2;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  lab5_if_id_reg #(
    .BUBBLE (NOP_WORD)
  ) u_if_id (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_hold  (w_hold),
    .i_flush (w_flush),
    .i_instr (IRAM_Q),
    .i_pcp2  (w_pcp2),
    .i_valid (1'b1),
    .o_instr (IF_INSTR),
    .o_pcp2  (IF_PCP2),
    .o_valid (IF_VALID)
  );

  assign IRAM_ADDR = r_pc;
  assign HALTED    = (r_state == HALT);
endmodule
